// File: rtl/debug_reg_scanner.sv
// Debug register scanner: walks the processor's debug select port and streams a
// framed snapshot (0xA5, PC, R0..R(NUM_REGS-1)), LSB first, over valid/ready.
module debug_reg_scanner #(
  parameter int NUM_REGS      = 16,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] debug_reg_out,
  input  logic [31:0] pc,
  output logic [3:0]  debug_reg_select,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        done
);

  localparam int               SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [4:0]       REG_COUNT   = 5'(NUM_REGS);
  localparam logic [7:0]       HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    SEND,
    WAIT,
    DONE
  } state_t;

  state_t              state;
  logic [31:0]         shiftWord;
  logic [1:0]          byteCount;
  logic [4:0]          regIndex;
  logic [SETTLE_W-1:0] settleCount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      shiftWord        <= 32'h0;
      byteCount        <= 2'd0;
      regIndex         <= 5'd0;
      settleCount      <= '0;
      debug_reg_select <= 4'd0;
      byte_data        <= 8'h00;
      byte_valid       <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state            <= HEADER;
            shiftWord        <= pc;
            regIndex         <= 5'd0;
            byteCount        <= 2'd0;
            debug_reg_select <= 4'd0;
            byte_data        <= HEADER_BYTE;
            byte_valid       <= 1'b1;
            busy             <= 1'b1;
          end
        end

        HEADER: begin
          if (byte_ready) begin
            state     <= SEND;
            byte_data <= shiftWord[7:0];
          end
        end

        // byte_data always mirrors the low byte of the shift word while sending
        SEND: begin
          if (byte_ready) begin
            byteCount <= byteCount + 2'd1;
            shiftWord <= {8'h00, shiftWord[31:8]};
            if (byteCount == 2'd3) begin
              byte_valid <= 1'b0;
              if (regIndex == REG_COUNT) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state            <= WAIT;
                debug_reg_select <= regIndex[3:0];
                settleCount      <= '0;
              end
            end else begin
              byte_data <= shiftWord[15:8];
            end
          end
        end

        // The processor keeps running, so the value is sampled exactly at the end of the hold
        WAIT: begin
          if (settleCount == SETTLE_LAST) begin
            state      <= SEND;
            shiftWord  <= debug_reg_out;
            regIndex   <= regIndex + 5'd1;
            byteCount  <= 2'd0;
            byte_data  <= debug_reg_out[7:0];
            byte_valid <= 1'b1;
          end else begin
            settleCount <= settleCount + 1'b1;
          end
        end

        DONE: begin
          state            <= IDLE;
          debug_reg_select <= 4'd0;
        end

        default: begin
          state      <= IDLE;
          byte_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_reg_scanner.sv
// Bench for debug_reg_scanner: two instances (settle 1 and settle 3) driven with
// directed and randomized frames, compared byte-by-byte against a frame model.
module tb_debug_reg_scanner;

  localparam int NUM_REGS = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start     [2];
  logic        byteReady [2];
  logic [31:0] pcIn      [2];
  logic [31:0] regBase   [2];
  logic [31:0] regOut    [2];
  logic [3:0]  sel       [2];
  logic [7:0]  bdata     [2];
  logic        bvalid    [2];
  logic        busy      [2];
  logic        done      [2];

  int passCount  = 0;
  int failCount  = 0;
  int totalCount = 0;

  always #5 clk = ~clk;

  debug_reg_scanner #(.NUM_REGS(NUM_REGS), .SETTLE_CYCLES(1)) dutFast (
    .clk(clk), .reset(reset), .start(start[0]),
    .debug_reg_out(regOut[0]), .pc(pcIn[0]),
    .debug_reg_select(sel[0]), .byte_data(bdata[0]), .byte_valid(bvalid[0]),
    .byte_ready(byteReady[0]), .busy(busy[0]), .done(done[0])
  );

  debug_reg_scanner #(.NUM_REGS(NUM_REGS), .SETTLE_CYCLES(3)) dutSlow (
    .clk(clk), .reset(reset), .start(start[1]),
    .debug_reg_out(regOut[1]), .pc(pcIn[1]),
    .debug_reg_select(sel[1]), .byte_data(bdata[1]), .byte_valid(bvalid[1]),
    .byte_ready(byteReady[1]), .busy(busy[1]), .done(done[1])
  );

  // Processor model for the slow unit: the read port needs 2 cycles after a new
  // select (or a new read request) before the value is trustworthy.
  int       age1      = 3;
  logic [3:0] lastSel1  = 4'd0;
  logic     lastValid1 = 1'b0;

  always @(negedge clk) begin
    if (sel[1] != lastSel1 || (lastValid1 && !bvalid[1])) age1 <= 0;
    else if (age1 < 3) age1 <= age1 + 1;
    lastSel1   <= sel[1];
    lastValid1 <= bvalid[1];
  end

  always_comb begin
    regOut[0] = regBase[0] + {28'd0, sel[0]};
    regOut[1] = (age1 < 2) ? ~(regBase[1] + {28'd0, sel[1]}) : (regBase[1] + {28'd0, sel[1]});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    totalCount++;
    assert (obs === expv) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic checkIdle(input int u, input string tag);
    check({tag, "_select"}, 32'(sel[u]), 32'd0);
    check({tag, "_data"}, 32'(bdata[u]), 32'h00);
    check({tag, "_valid"}, 32'(bvalid[u]), 32'd0);
    check({tag, "_busy"}, 32'(busy[u]), 32'd0);
    check({tag, "_done"}, 32'(done[u]), 32'd0);
  endtask

  // readyMode: 0 always ready, 1 toggling 1/0, 2 random gaps.
  // startMode: 0 single pulse, 1 extra pulse mid-scan, 2 start held high.
  // abortPos: stream position at which reset is asserted (-1 = none).
  task automatic runFrame(input int u, input logic [31:0] pcVal, input logic [31:0] base,
                          input int readyMode, input int startMode, input int abortPos);
    logic [7:0]  expq[$];
    logic [31:0] word;
    int settle = (u == 0) ? 1 : 3;
    int sent = 0;
    int lastCycle = -1;
    bit finished = 0;
    bit aborted = 0;
    bit r;
    logic       prevValid = 1'b0;
    logic       prevReady = 1'b1;
    logic [7:0] prevData = 8'h00;
    logic [3:0] prevSel = 4'd0;

    expq.push_back(8'hA5);
    for (int w = 0; w <= NUM_REGS; w++) begin
      word = (w == 0) ? pcVal : base + 32'(w - 1);
      for (int b = 0; b < 4; b++) expq.push_back(word[8*b +: 8]);
    end

    @(negedge clk);
    pcIn[u]      = pcVal;
    regBase[u]   = base;
    start[u]     = 1'b1;
    byteReady[u] = 1'b1;

    for (int n = 1; n < 2000 && !finished; n++) begin
      @(negedge clk);
      if (n == 1) begin
        pcIn[u] = ~pcVal;
        if (startMode != 2) start[u] = 1'b0;
      end
      if (startMode == 1) start[u] = (n == 30);

      if (prevValid && !prevReady) begin
        check("hold_valid", 32'(bvalid[u]), 32'd1);
        check("hold_data", 32'(bdata[u]), 32'(prevData));
        check("hold_select", 32'(sel[u]), 32'(prevSel));
      end

      if (lastCycle < 0) begin
        check("busy_in_frame", 32'(busy[u]), 32'd1);
        check("done_in_frame", 32'(done[u]), 32'd0);
      end else if (n == lastCycle + 1) begin
        check("done_pulse", 32'(done[u]), 32'd1);
        check("busy_at_done", 32'(busy[u]), 32'd0);
        check("valid_at_done", 32'(bvalid[u]), 32'd0);
        continue;
      end else if (n == lastCycle + 2) begin
        check("done_cleared", 32'(done[u]), 32'd0);
        check("idle_busy", 32'(busy[u]), 32'd0);
        check("idle_valid", 32'(bvalid[u]), 32'd0);
        if (startMode != 2) finished = 1;
        continue;
      end else begin
        check("restart_header_valid", 32'(bvalid[u]), 32'd1);
        check("restart_header_data", 32'(bdata[u]), 32'hA5);
        check("restart_busy", 32'(busy[u]), 32'd1);
        finished = 1;
        continue;
      end

      if (!bvalid[u]) check($sformatf("wait_select_w%0d", (sent - 1) / 4), 32'(sel[u]), 32'((sent - 1) / 4 - 1));
      else if (sent >= 5) check($sformatf("send_select_b%0d", sent), 32'(sel[u]), 32'((sent - 1) / 4 - 1));

      case (readyMode)
        0:       r = 1'b1;
        1:       r = (n % 2 == 1);
        default: r = ($urandom_range(0, 2) != 0);
      endcase
      byteReady[u] = r;

      if (abortPos >= 0 && bvalid[u] && sent == abortPos) begin
        reset = 1'b1;
        #1;
        checkIdle(u, "abort_reset");
        @(negedge clk);
        reset = 1'b0;
        aborted = 1;
        break;
      end

      if (bvalid[u] && r) begin
        if (sent < expq.size()) check($sformatf("byte%0d", sent), 32'(bdata[u]), 32'(expq[sent]));
        else check("extra_byte", 32'(sent), 32'(expq.size() - 1));
        sent++;
        if (sent == expq.size()) begin
          lastCycle = n;
          if (readyMode == 0) check("last_byte_cycle", 32'(n), 32'(5 + NUM_REGS * (settle + 4)));
        end
      end

      prevValid = bvalid[u];
      prevReady = r;
      prevData  = bdata[u];
      prevSel   = sel[u];
    end

    if (!aborted) begin
      check("frame_complete", 32'(finished), 32'd1);
      check("frame_length", 32'(sent), 32'(expq.size()));
    end
    byteReady[u] = 1'b1;
    $display("frame unit=%0d pc=%08h base=%08h ready_mode=%0d start_mode=%0d bytes=%0d last_cycle=%0d",
             u, pcVal, base, readyMode, startMode, sent, lastCycle);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start[i]     = 1'b0;
      byteReady[i] = 1'b1;
      pcIn[i]      = 32'h0;
      regBase[i]   = 32'h1000_0000;
    end

    #2 reset = 1'b1;
    #1;
    checkIdle(0, "reset_fast");
    checkIdle(1, "reset_slow");
    @(negedge clk);
    reset = 1'b0;

    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("idle_no_start_valid", 32'(bvalid[0]), 32'd0);
      check("idle_no_start_busy", 32'(busy[0]), 32'd0);
    end

    runFrame(0, 32'h0000_0040, 32'h1000_0000, 0, 0, -1);
    runFrame(0, 32'h0000_0040, 32'h1000_0000, 1, 0, -1);
    runFrame(0, $urandom, $urandom, 2, 1, -1);
    runFrame(1, $urandom, $urandom, 0, 0, -1);
    runFrame(1, $urandom, $urandom, 2, 1, -1);

    runFrame(0, 32'h0000_0040, 32'h1000_0000, 0, 2, -1);
    start[0] = 1'b0;
    #1 reset = 1'b1;
    #1;
    checkIdle(0, "reset_after_hold");
    @(negedge clk);
    reset = 1'b0;

    runFrame(0, 32'h0000_0040, 32'h1000_0000, 0, 0, 35);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_abort_valid", 32'(bvalid[0]), 32'd0);
      check("post_abort_busy", 32'(busy[0]), 32'd0);
    end
    runFrame(0, 32'h0000_0040, 32'h1000_0000, 0, 0, -1);
    runFrame(0, $urandom, $urandom, 2, 0, -1);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
